pci_int_arbiter: RTL and testbench

PCI_INT_ARBITER -- requirements
Module: pci_int_arbiter

---
 rtl/pci_int_arbiter_pkg.sv | 10 +
 rtl/pci_rr_pick.sv | 35 +++
 rtl/pci_int_arbiter.sv | 99 +++++++++
 tb/tb_pci_int_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_int_arbiter_pkg.sv
// Shared definitions for the PCI interrupt arbiter: FSM state encodings.
package pci_int_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin picker: lowest request at or above ptr, else lowest overall.
module pci_rr_pick #(
  parameter int unsigned COUNT      = 16,
  parameter int unsigned COUNT_BITS = 4
) (
  input  logic [COUNT-1:0]      req,
  input  logic [COUNT_BITS-1:0] ptr,
  output logic                  found,
  output logic [COUNT_BITS-1:0] idx
);

  logic                  upper_found;
  logic [COUNT_BITS-1:0] upper_idx;
  logic [COUNT_BITS-1:0] lower_idx;

  always_comb begin
    found       = 1'b0;
    upper_found = 1'b0;
    upper_idx   = '0;
    lower_idx   = '0;
    // Scan downward so the last hit in each class is the lowest index.
    for (int i = int'(COUNT) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found     = 1'b1;
        lower_idx = COUNT_BITS'(i);
        if (i >= int'(ptr)) begin
          upper_found = 1'b1;
          upper_idx   = COUNT_BITS'(i);
        end
      end
    end
    idx = upper_found ? upper_idx : lower_idx;
  end

endmodule

// File: rtl/pci_int_arbiter.sv
// Interrupt event collector and round-robin issuer towards the MSI sender, with holdoff.
module pci_int_arbiter
  import pci_int_arbiter_pkg::*;
#(
  parameter int unsigned COUNT        = 16,
  parameter int unsigned COUNT_BITS   = 4,
  parameter int unsigned HOLDOFF_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COUNT-1:0]        int_req,
  input  logic [COUNT-1:0]        int_mask,
  input  logic                    int_en,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  output logic [COUNT_BITS-1:0]   m_int_data,
  output logic                    m_int_valid,
  input  logic                    m_int_ready,
  output logic [COUNT-1:0]        int_pending
);

  arb_state_e              state_q;
  logic [COUNT-1:0]        pending_q;
  logic [COUNT-1:0]        pending_d;
  logic [COUNT-1:0]        eligible;
  logic [COUNT-1:0]        grant_clr;
  logic [COUNT_BITS-1:0]   ptr_q;
  logic [COUNT_BITS-1:0]   ptr_inc;
  logic [COUNT_BITS-1:0]   data_q;
  logic [COUNT_BITS-1:0]   pick_idx;
  logic                    pick_found;
  logic                    valid_q;
  logic                    handshake;
  logic [HOLDOFF_BITS-1:0] cnt_q;

  assign handshake = valid_q & m_int_ready;
  assign eligible  = int_en ? (pending_q & ~int_mask) : '0;

  always_comb begin
    grant_clr = '0;
    if (handshake) grant_clr[data_q] = 1'b1;
    // A pulse on the source being acknowledged survives the clear, so it is reissued.
    pending_d = (pending_q & ~grant_clr) | int_req;
    ptr_inc   = (data_q == COUNT_BITS'(COUNT - 1)) ? '0 : data_q + COUNT_BITS'(1);
  end

  pci_rr_pick #(
    .COUNT      (COUNT),
    .COUNT_BITS (COUNT_BITS)
  ) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            data_q  <= pick_idx;
            valid_q <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (m_int_ready) begin
            valid_q <= 1'b0;
            ptr_q   <= ptr_inc;
            if (holdoff != '0) begin
              cnt_q   <= holdoff;
              state_q <= StHold;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StHold: begin
          cnt_q <= cnt_q - HOLDOFF_BITS'(1);
          if (cnt_q <= HOLDOFF_BITS'(1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_int_data  = data_q;
  assign m_int_valid = valid_q;
  assign int_pending = pending_q;

endmodule

// File: tb/tb_pci_int_arbiter.sv
// Scoreboard bench for pci_int_arbiter: reference model predicts grants, monitor compares.
module tb_pci_int_arbiter;

  localparam int NSRC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSRC-1:0]   int_req;
  logic [NSRC-1:0]   int_mask;
  logic              int_en;
  logic [15:0]       holdoff;
  logic [3:0]        m_int_data;
  logic              m_int_valid;
  logic              m_int_ready;
  logic [NSRC-1:0]   int_pending;

  always #5 clk = ~clk;

  pci_int_arbiter #(
    .COUNT        (NSRC),
    .COUNT_BITS   (4),
    .HOLDOFF_BITS (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_req     (int_req),
    .int_mask    (int_mask),
    .int_en      (int_en),
    .holdoff     (holdoff),
    .m_int_data  (m_int_data),
    .m_int_valid (m_int_valid),
    .m_int_ready (m_int_ready),
    .int_pending (int_pending)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model state: pending set, rotation pointer, offered index, earliest pick edge.
  bit [NSRC-1:0] m_pend;
  int            m_ptr;
  int            m_offer;
  int            m_edge;
  int            m_ready_edge;
  int            exp_q[$];

  int hs_log[$];
  int hs_cyc[$];
  int ncyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input bit [NSRC-1:0] elig, input int ptr);
    for (int k = 0; k < NSRC; k++) begin
      int j;
      j = (ptr + k) % NSRC;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge();
    bit [NSRC-1:0] elig;
    bit [NSRC-1:0] nxt;
    int            w;
    elig = int_en ? (m_pend & ~int_mask) : '0;
    nxt  = m_pend;
    m_edge++;
    if (m_offer >= 0) begin
      if (m_int_ready) begin
        nxt[m_offer] = 1'b0;
        m_ptr        = (m_offer + 1) % NSRC;
        m_offer      = -1;
        m_ready_edge = m_edge + int'(holdoff) + 1;
      end
    end else if (m_edge >= m_ready_edge) begin
      w = rr_pick(elig, m_ptr);
      if (w >= 0) begin
        m_offer = w;
        exp_q.push_back(w);
      end
    end
    m_pend = nxt | int_req;
  endtask

  initial begin
    m_pend = '0; m_ptr = 0; m_offer = -1; m_edge = 0; m_ready_edge = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend = '0; m_ptr = 0; m_offer = -1; m_edge = 0; m_ready_edge = 0;
        exp_q.delete();
      end else begin
        model_edge();
      end
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (mon_en && rst_n) begin
        check("valid", 32'(m_int_valid), 32'(m_offer >= 0));
        if (m_offer >= 0) check("data_hold", 32'(m_int_data), m_offer);
        check("pending", 32'(int_pending), 32'(m_pend));
        if (m_int_valid && m_int_ready) begin
          hs_log.push_back(int'(m_int_data));
          hs_cyc.push_back(ncyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant_unexpected: got index %0d, expected none", m_int_data);
          end else begin
            check("grant", 32'(m_int_data), exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    int_req = v;
    tick(1);
    int_req = '0;
  endtask

  task automatic do_reset();
    int_req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(m_int_valid), 32'd0);
    check("rst_pending", 32'(int_pending), 32'd0);
    check("rst_data", 32'(m_int_data), 32'd0);
    tick(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    hs_log.delete();
    hs_cyc.delete();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (m_int_valid !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(m_int_valid), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((int_pending !== '0 || m_int_valid !== 1'b0) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(int_pending === '0 && m_int_valid === 1'b0), 32'd1);
  endtask

  task automatic wait_hs(input string name, input int cnt, input int budget);
    int n = 0;
    while (hs_log.size() < cnt && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(hs_log.size() >= cnt), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; int_req = '0; int_mask = '0; int_en = 1'b1;
    holdoff = '0; m_int_ready = 1'b0;
    do_reset();

    // Basic issue: two-cycle latency and clear on handshake.
    m_int_ready = 1'b1;
    pulse(16'h0008);
    check("lat_early_valid", 32'(m_int_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(m_int_valid), 32'd1);
    check("lat_data", 32'(m_int_data), 32'd3);
    tick(1);
    check("clr_pend3", 32'(int_pending[3]), 32'd0);
    wait_idle("basic_idle", 20);

    // Round-robin fairness with three continuously pending sources.
    do_reset();
    m_int_ready = 1'b1;
    int_req = 16'h0222;
    tick(14);
    int_req = '0;
    wait_idle("rr_idle", 40);
    check("rr_count", 32'(hs_log.size() >= 6), 32'd1);
    if (hs_log.size() >= 6)
      for (int i = 0; i < 6; i++)
        check("rr_order", hs_log[i], (i % 3 == 0) ? 1 : (i % 3 == 1) ? 5 : 9);

    // Pointer wrap: after granting 14, order is 15 then 0.
    do_reset();
    m_int_ready = 1'b1;
    pulse(16'h4000);
    wait_idle("wrap_idle0", 20);
    pulse(16'h8001);
    wait_idle("wrap_idle1", 20);
    check("wrap_count", 32'(hs_log.size()), 32'd3);
    if (hs_log.size() == 3) begin
      check("wrap_g0", hs_log[0], 14);
      check("wrap_g1", hs_log[1], 15);
      check("wrap_g2", hs_log[2], 0);
    end

    // Backpressure with toggling mask; pointer is 1 here.
    m_int_ready = 1'b0;
    pulse(16'h0050);
    wait_valid("bp_valid", 10);
    for (int i = 0; i < 10; i++) begin
      int_mask = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      tick(1);
      check("bp_valid_hold", 32'(m_int_valid), 32'd1);
      check("bp_data_hold", 32'(m_int_data), 32'd4);
    end
    int_mask = '0;
    m_int_ready = 1'b1;
    tick(1);
    check("bp_hs_valid", 32'(m_int_valid), 32'd0);
    check("bp_pend4", 32'(int_pending[4]), 32'd0);
    check("bp_pend6", 32'(int_pending[6]), 32'd1);
    wait_idle("bp_idle", 20);

    // New pulse on source 2 coinciding with its handshake.
    m_int_ready = 1'b0;
    pulse(16'h0004);
    wait_valid("sim_valid", 10);
    check("sim_data", 32'(m_int_data), 32'd2);
    m_int_ready = 1'b1;
    int_req = 16'h0004;
    tick(1);
    int_req = '0;
    check("sim_pend2", 32'(int_pending[2]), 32'd1);
    tick(1);
    check("sim_reissue_valid", 32'(m_int_valid), 32'd1);
    check("sim_reissue_data", 32'(m_int_data), 32'd2);
    wait_idle("sim_idle", 20);

    // Holdoff spacing and masked source; pointer is 3 here.
    holdoff = 16'd5;
    int_mask = 16'h0800;
    hs_log.delete();
    hs_cyc.delete();
    pulse(16'h1C00);
    wait_hs("ho_hs", 2, 40);
    if (hs_log.size() >= 2) begin
      check("ho_spacing", hs_cyc[1] - hs_cyc[0], 7);
      check("ho_g0", hs_log[0], 10);
      check("ho_g1", hs_log[1], 12);
    end
    tick(15);
    check("ho_masked_count", 32'(hs_log.size()), 32'd2);
    check("ho_masked_pend", 32'(int_pending[11]), 32'd1);
    holdoff = '0;
    int_mask = '0;
    tick(1);
    check("ho_unmask_valid", 32'(m_int_valid), 32'd1);
    check("ho_unmask_data", 32'(m_int_data), 32'd11);
    wait_idle("ho_idle", 20);

    // Reset during ISSUE; pointer was 12, next grant must restart from 0.
    m_int_ready = 1'b0;
    pulse(16'h0100);
    wait_valid("rst_issue_valid", 10);
    do_reset();
    m_int_ready = 1'b1;
    pulse(16'h1001);
    wait_idle("rst_idle", 20);
    check("rst_count", 32'(hs_log.size()), 32'd2);
    if (hs_log.size() == 2) begin
      check("rst_g0", hs_log[0], 0);
      check("rst_g1", hs_log[1], 12);
    end

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      int_req = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : '0;
      if ($urandom_range(0, 15) == 0) int_mask = 16'($urandom) & 16'($urandom);
      int_en = ($urandom_range(0, 15) != 0);
      m_int_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 31) == 0) holdoff = 16'($urandom_range(0, 3));
      tick(1);
    end

    int_req = '0; int_mask = '0; int_en = 1'b1; holdoff = '0; m_int_ready = 1'b1;
    wait_idle("final_idle", 200);
    tick(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
